fetch_stage: RTL

- Instruction-fetch front end of the RISC-V pipeline, directly upstream of decode.
- Holds the PC and issues word requests to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap target) from EX; a redirect flushes all buffered and in-flight fetches.

---
 rtl/fetch_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, 1-cycle imem requests, instruction FIFO to decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushes counters.
module fetch_stage #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushes
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fentry_t;

  fentry_t         mem [FIFO_DEPTH];
  fentry_t         head;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_tgt;
  logic            inflight;
  logic            kill;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   occ;
  logic [PW:0]     credit;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  assign occ    = wptr - rptr;
  assign credit = {1'b0, occ} + {{PW{1'b0}}, inflight};
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

  // Credit counts buffered plus in-flight words, so a push always fits.
  assign imem_req  = rst && !redirect_valid &&
                     (credit < (PW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;

  assign push = rst && inflight && !kill &&
                !redirect_valid && !full;

  assign head     = mem[rptr[AW-1:0]];
  assign id_valid = rst && !empty && !redirect_valid;
  assign id_instr = empty ? 32'h0 : head.instr;
  assign id_pc    = empty ? '0 : head.pc;
  assign pop      = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      inflight <= 1'b0;
      kill     <= inflight;
      rptr     <= wptr;
    end else begin
      kill     <= 1'b0;
      inflight <= imem_req;
      if (imem_req) begin
        pc_q     <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= '{instr: imem_rdata, pc: pc_q};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= 32'h0;
      perf_flushes <= 32'h0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'h1;
      if (redirect_valid && (!empty || inflight))
        perf_flushes <= perf_flushes + 32'h1;
    end
  end
`endif

endmodule
